// File: rtl/dadda_mac.sv
// -----------------------------------------------------------------------------
// dadda_mac
//   Multiply-accumulate stage built around a 4x4 Dadda multiplier. Unsigned
//   operand pairs arrive over a valid/ready handshake and their products are
//   summed into a running accumulator. When the element flagged last has been
//   accumulated, the dot product is presented over a second valid/ready
//   handshake and held until the consumer takes it.
//
//   Pipeline: S1 operand register -> Dadda tree -> S2 product register ->
//   S3 accumulate. A last element accepted in cycle t is presented in t+3.
//
// Ports (dadda_mac)
//   clk        in   rising-edge clock
//   rst        in   synchronous, active-high reset
//   in_valid   in   operand pair valid
//   in_ready   out  stage can accept an operand pair
//   in_a       in   [N-1:0] unsigned multiplicand
//   in_b       in   [N-1:0] unsigned multiplier
//   in_last    in   final element of the current dot product
//   out_valid  out  result valid
//   out_ready  in   consumer accepts result
//   out_acc    out  [ACC_W-1:0] accumulated sum, mod 2^ACC_W
//   out_count  out  [CNT_W-1:0] number of products accumulated, mod 2^CNT_W
//   out_ovf    out  sticky carry-out of the accumulator for this result
//
// Ports (dadda_mul4)
//   i_a, i_b   in   [3:0] unsigned operands
//   o_p        out  [7:0] unsigned product
// -----------------------------------------------------------------------------

module dadda_mul4 (
    input  logic [3:0] i_a,
    input  logic [3:0] i_b,
    output logic [7:0] o_p
);
    // Partial products; w_pp[i][j] = a[i] & b[j] carries weight i+j.
    logic [3:0] w_pp [4];

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            for (int j = 0; j < 4; j++) begin
                w_pp[i][j] = i_a[i] & i_b[j];
            end
        end
    end

    // Stage 1: reduce max column height 4 -> 3 (half adders in columns 3, 4).
    logic w_s1_3, w_c1_4, w_s1_4, w_c1_5;
    assign w_s1_3 = w_pp[0][3] ^ w_pp[1][2];
    assign w_c1_4 = w_pp[0][3] & w_pp[1][2];
    assign w_s1_4 = w_pp[1][3] ^ w_pp[2][2];
    assign w_c1_5 = w_pp[1][3] & w_pp[2][2];

    // Stage 2: reduce max column height 3 -> 2.
    logic w_s2_2, w_c2_3, w_s2_3, w_c2_4, w_s2_4, w_c2_5, w_s2_5, w_c2_6;
    assign w_s2_2 = w_pp[0][2] ^ w_pp[1][1];
    assign w_c2_3 = w_pp[0][2] & w_pp[1][1];
    assign w_s2_3 = w_s1_3 ^ w_pp[2][1] ^ w_pp[3][0];
    assign w_c2_4 = (w_s1_3 & w_pp[2][1]) | (w_s1_3 & w_pp[3][0]) | (w_pp[2][1] & w_pp[3][0]);
    assign w_s2_4 = w_s1_4 ^ w_pp[3][1] ^ w_c1_4;
    assign w_c2_5 = (w_s1_4 & w_pp[3][1]) | (w_s1_4 & w_c1_4) | (w_pp[3][1] & w_c1_4);
    assign w_s2_5 = w_pp[2][3] ^ w_pp[3][2] ^ w_c1_5;
    assign w_c2_6 = (w_pp[2][3] & w_pp[3][2]) | (w_pp[2][3] & w_c1_5) | (w_pp[3][2] & w_c1_5);

    // Final carry-propagate add of the two remaining rows.
    logic [7:0] w_row_x, w_row_y;
    assign w_row_x = {1'b0, w_pp[3][3], w_s2_5, w_s2_4, w_s2_3, w_s2_2, w_pp[0][1], w_pp[0][0]};
    assign w_row_y = {1'b0, w_c2_6, w_c2_5, w_c2_4, w_c2_3, w_pp[2][0], w_pp[1][0], 1'b0};
    assign o_p     = w_row_x + w_row_y;
endmodule

module dadda_mac #(
    parameter int N     = 4,
    parameter int ACC_W = 12,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [N-1:0]     in_a,
    input  logic [N-1:0]     in_b,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_acc,
    output logic [CNT_W-1:0] out_count,
    output logic             out_ovf
);
    localparam int PAD = ACC_W - 2 * N;

    typedef enum logic {ST_ACCUM, ST_HOLD} state_t;

    state_t           r_state, w_next_state;
    logic             r_s1_valid, r_s1_last;
    logic [N-1:0]     r_s1_a, r_s1_b;
    logic             r_s2_valid, r_s2_last;
    logic [2*N-1:0]   r_s2_prod;
    logic [ACC_W-1:0] r_acc;
    logic [CNT_W-1:0] r_count;
    logic             r_ovf;
    logic             r_last_seen;   // last element accepted, still draining

    logic [2*N-1:0]   w_prod;
    logic [ACC_W:0]   w_sum;
    logic             w_accept, w_commit_last, w_out_fire;

    dadda_mul4 u_mul (
        .i_a (r_s1_a),
        .i_b (r_s1_b),
        .o_p (w_prod)
    );

    assign w_accept      = in_valid && in_ready;
    assign w_commit_last = r_s2_valid && r_s2_last;
    assign w_out_fire    = out_valid && out_ready;
    // Extra top bit captures the carry out of the ACC_W-bit add.
    assign w_sum         = {1'b0, r_acc} + {{(PAD + 1){1'b0}}, r_s2_prod};

    // NOTE: every signal driven here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        w_next_state = r_state;
        in_ready     = 1'b0;
        out_valid    = 1'b0;
        unique case (r_state)
            ST_ACCUM: begin
                in_ready = !r_last_seen;
                if (w_commit_last) w_next_state = ST_HOLD;
            end
            ST_HOLD: begin
                out_valid = 1'b1;
                if (out_ready) w_next_state = ST_ACCUM;
            end
            default: w_next_state = ST_ACCUM;
        endcase
        // Running sums stay hidden until the result is complete.
        out_acc   = out_valid ? r_acc   : '0;
        out_count = out_valid ? r_count : '0;
        out_ovf   = out_valid && r_ovf;
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_ACCUM;
            r_s1_valid  <= 1'b0;
            r_s1_last   <= 1'b0;
            r_s2_valid  <= 1'b0;
            r_s2_last   <= 1'b0;
            r_last_seen <= 1'b0;
            r_acc       <= '0;
            r_count     <= '0;
            r_ovf       <= 1'b0;
        end else begin
            r_state    <= w_next_state;
            r_s1_valid <= w_accept;
            r_s1_last  <= w_accept && in_last;
            r_s2_valid <= r_s1_valid;
            r_s2_last  <= r_s1_valid && r_s1_last;

            if (w_accept && in_last) r_last_seen <= 1'b1;
            else if (w_commit_last)  r_last_seen <= 1'b0;

            if (w_out_fire) begin
                r_acc   <= '0;
                r_count <= '0;
                r_ovf   <= 1'b0;
            end else if (r_s2_valid) begin
                r_acc   <= w_sum[ACC_W-1:0];
                r_count <= r_count + CNT_W'(1);
                r_ovf   <= r_ovf | w_sum[ACC_W];
            end
        end
    end

    // NOTE: payload registers carry no reset; they are only consumed when the
    // matching valid bit, which is reset, says they hold real data.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_s1_a <= in_a;
            r_s1_b <= in_b;
        end
        r_s2_prod <= w_prod;
    end
endmodule

// File: tb/tb_dadda_mac.sv
// -----------------------------------------------------------------------------
// tb_dadda_mac
//   Self-checking bench for dadda_mac (N=4, ACC_W=12, CNT_W=8). A driver feeds
//   dot products and, on each last element, pushes the expected result computed
//   with plain integer arithmetic into a queue. A monitor pops and compares
//   whenever the DUT presents a result, and also watches latency, in_ready and
//   output stability while the result is held.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_dadda_mac;
    localparam int N     = 4;
    localparam int ACC_W = 12;
    localparam int CNT_W = 8;

    typedef struct {
        int acc;
        int cnt;
        int ovf;
        int cyc;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [N-1:0]     in_a;
    logic [N-1:0]     in_b;
    logic             in_last;
    logic             out_valid;
    logic             out_ready;
    logic [ACC_W-1:0] out_acc;
    logic [CNT_W-1:0] out_count;
    logic             out_ovf;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;
    int   n_last_sent = 0;
    int   n_done      = 0;
    int   m_sum = 0;
    int   m_cnt = 0;

    dadda_mac #(.N(N), .ACC_W(ACC_W), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_acc   (out_acc),
        .out_count (out_count),
        .out_ovf   (out_ovf)
    );

    always #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    initial begin
        #800000;
        $display("FAIL global_timeout: got running want finished");
        $fatal(1, "timeout");
    end

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Drive one element; model update and expected-result push on acceptance.
    task automatic send(input int a, input int b, input bit last);
        int   stalls = 0;
        int   t;
        exp_t e;
        in_valid = 1'b1;
        in_a     = N'(a);
        in_b     = N'(b);
        in_last  = last;
        @(negedge clk);
        while (!in_ready && stalls < 100) begin
            @(negedge clk);
            stalls++;
        end
        if (!in_ready) begin
            check("accept_timeout", 0, 1);
            in_valid = 1'b0;
            in_last  = 1'b0;
            return;
        end
        check("in_ready_on_accept", stalls, 0);
        t = cyc;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
        m_sum += a * b;
        m_cnt += 1;
        if (last) begin
            e.acc = m_sum % (1 << ACC_W);
            e.cnt = m_cnt % (1 << CNT_W);
            e.ovf = (m_sum >= (1 << ACC_W)) ? 1 : 0;
            e.cyc = t + 3;
            exp_q.push_back(e);
            m_sum = 0;
            m_cnt = 0;
            n_last_sent++;
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Wait for the result, optionally hold off out_ready for bp cycles.
    task automatic collect(input int bp);
        int guard = 0;
        out_ready = (bp == 0);
        @(negedge clk);
        while (!out_valid && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        if (!out_valid) begin
            check("result_timeout", 0, 1);
            out_ready = 1'b1;
            return;
        end
        if (bp > 0) begin
            repeat (bp) @(negedge clk);
            @(posedge clk);
            #1;
            out_ready = 1'b1;
        end
        guard = 0;
        while (out_valid && guard < 10) begin
            @(negedge clk);
            guard++;
        end
        check("result_released", int'(out_valid), 0);
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_in_ready"},  int'(in_ready),  1);
        check({tag, "_out_valid"}, int'(out_valid), 0);
        check({tag, "_out_acc"},   int'(out_acc),   0);
        check({tag, "_out_count"}, int'(out_count), 0);
        check({tag, "_out_ovf"},   int'(out_ovf),   0);
    endtask

    // Monitor: compares presented results against the scoreboard queue.
    initial begin
        exp_t cur;
        bit   have = 1'b0;
        bit   hs_pending = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                have       = 1'b0;
                hs_pending = 1'b0;
            end else begin
                if (hs_pending) begin
                    check("valid_drop_after_hs", int'(out_valid), 0);
                    check("ready_after_hs",      int'(in_ready),  1);
                    hs_pending = 1'b0;
                    have       = 1'b0;
                    n_done++;
                end
                if (out_valid) begin
                    if (!have) begin
                        if (exp_q.size() == 0) begin
                            check("unexpected_result", 1, 0);
                        end else begin
                            cur  = exp_q.pop_front();
                            have = 1'b1;
                            check("latency_cycle", cyc, cur.cyc);
                        end
                    end
                    if (have) begin
                        check("out_acc",   int'(out_acc),   cur.acc);
                        check("out_count", int'(out_count), cur.cnt);
                        check("out_ovf",   int'(out_ovf),   cur.ovf);
                    end
                    if (out_ready) hs_pending = 1'b1;
                end
                if (out_valid || (n_last_sent != n_done)) begin
                    check("in_ready_low_while_busy", int'(in_ready), 0);
                end
            end
        end
    end

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_a      = '0;
        in_b      = '0;
        in_last   = 1'b0;
        out_ready = 1'b1;
        idle(3);
        rst = 1'b0;
        @(negedge clk);
        check_reset_outputs("reset");
        @(posedge clk);
        #1;

        // Single element 15x15.
        send(15, 15, 1'b1);
        collect(0);

        // Back-to-back stream: 1*2 + 2*3 + 3*4 + 4*5 = 40.
        for (int i = 0; i < 4; i++) send(i + 1, i + 2, i == 3);
        collect(0);

        // Same stream with random bubbles.
        for (int i = 0; i < 4; i++) begin
            send(i + 1, i + 2, i == 3);
            if (i < 3) idle($urandom_range(0, 3));
        end
        collect(0);

        // Accumulator wrap: 19 * 225 = 4275 -> 179 with overflow.
        for (int i = 0; i < 19; i++) send(15, 15, i == 18);
        collect(0);
        send(2, 3, 1'b1);
        collect(0);

        // Backpressure: hold the result for 5 cycles.
        send(7, 9, 1'b1);
        collect(5);

        // Reset after two of four elements; partial sum is discarded.
        send(5, 6, 1'b0);
        send(7, 8, 1'b0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst   = 1'b0;
        m_sum = 0;
        m_cnt = 0;
        @(negedge clk);
        check_reset_outputs("mid_reset");
        idle(6);
        send(3, 3, 1'b1);
        collect(0);

        // Random dot products with random bubbles and backpressure.
        for (int d = 0; d < 8; d++) begin
            int len;
            len = $urandom_range(1, 8);
            for (int i = 0; i < len; i++) begin
                send($urandom_range(0, 15), $urandom_range(0, 15), i == len - 1);
                if (i < len - 1) idle($urandom_range(0, 3));
            end
            collect($urandom_range(0, 3));
        end

        // Counter wrap: 260 elements -> count 4.
        for (int i = 0; i < 260; i++) send($urandom_range(0, 15), $urandom_range(0, 15), i == 259);
        collect(0);

        idle(4);
        check("scoreboard_empty", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
